// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, D = A - B mod 2^W.
// One full-subtractor cell and a registered borrow handle one bit per clock,
// LSB first. The block is driven by a start/busy/done handshake. Results and
// flags hold until the next operation completes.
//
// Optional feature: define SERSUB_ADD_MODE_EN to add an `op` input.
// When op is 1 the operation is A + B, and bout reports the carry-out.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SERSUB_ADD_MODE_EN
  input  logic         op,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int            CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sa_q, sb_q;     // operand shift registers, bit i at [0]
  logic [W-1:0]  res_q;          // result shift register, filled from the MSB
  logic [CW-1:0] cnt_q;          // index of the bit processed at the next edge
  logic          br_q;           // borrow (or carry in add mode) into bit i
  logic          am_q, bm_q;     // operand sign bits, kept for the overflow flag
`ifdef SERSUB_ADD_MODE_EN
  logic          op_q;
`endif

  logic          ai, bi, di, br_next, ovf_next;
  logic [W-1:0]  res_next;

  // Single arithmetic cell plus the values committed on the final bit.
  // NOTE: every always_comb output is assigned unconditionally or given a
  // default first, so no path leaves a signal unassigned and no latch appears.
  always_comb begin
    ai       = sa_q[0];
    bi       = sb_q[0];
    di       = ai ^ bi ^ br_q;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    ovf_next = (am_q != bm_q) && (di != am_q);
`ifdef SERSUB_ADD_MODE_EN
    if (op_q) begin
      br_next  = (ai & bi) | ((ai ^ bi) & br_q);
      ovf_next = (am_q == bm_q) && (di != am_q);
    end
`endif
    res_next = {di, res_q[W-1:1]};
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch operands on an accepted start, shift one bit per RUN edge,
  // and publish the result and flags on the last bit.
  // NOTE: reset clears every datapath register, including the shift registers.
  // An aborted operation therefore leaves no stale bits behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q  <= '0;
      sb_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
`ifdef SERSUB_ADD_MODE_EN
      op_q  <= 1'b0;
`endif
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sa_q  <= a;
            sb_q  <= b;
            am_q  <= a[W-1];
            bm_q  <= b[W-1];
            res_q <= '0;
            cnt_q <= '0;
            br_q  <= 1'b0;
`ifdef SERSUB_ADD_MODE_EN
            op_q  <= op;
`endif
          end
        end
        S_RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          res_q <= res_next;
          br_q  <= br_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            d    <= res_next;
            bout <= br_next;
            ovf  <= ovf_next;
            zero <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor. It computes D = A − B one bit per clock with a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the combinational full-adder datapath, and the ALU control sequences it through a start/busy/done handshake. Operands are latched on start, and the result and flags stay stable until the next accepted start.

## Interface
- `W`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  input  1: rising-edge clock; the only clock.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a new operation; sampled only in IDLE.
- `a`  input  W: minuend; latched on the accepted start edge.
- `b`  input  W: subtrahend; latched on the accepted start edge.
- `busy`  output  1: high while in RUN.
- `done`  output  1: single-cycle pulse; the result is valid from this cycle on.
- `d`  output  W: difference, A − B mod 2^W.
- `bout`  output  1: final borrow; 1 means A < B unsigned.
- `ovf`  output  1: signed overflow.
- `zero`  output  1: d == 0.

## Operation
- States and transitions:
  - IDLE → RUN on `start` = 1 at an edge.
  - RUN → DONE after W bit cycles.
  - DONE → IDLE unconditionally after one cycle.
- Accepted start:
  - latch `a` and `b` into shift registers;
  - borrow register br = 0;
  - bit counter cnt = 0;
  - result shift register = 0.
- Each RUN edge processes bit i = cnt, LSB first:
  - di = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - The operand registers shift right by 1.
  - The result register shifts right with di inserted at the MSB.
  - cnt increments.
- The edge with cnt = W−1 moves the FSM to DONE. On that same edge:
  - `d` takes the result register contents;
  - `bout` = br_next;
  - `ovf` = (a[W−1] != b[W−1]) && (d[W−1] != a[W−1]), using the latched operands;
  - `zero` = (d == 0).
- `done` = 1 only in DONE. `busy` = 1 only in RUN.
- `start` is ignored in RUN and in DONE; the ignored request is not queued.
- `d`, `bout`, `ovf` and `zero` hold their values through IDLE. They change only at the DONE transition of a later operation or on reset.
- `rst` = 1 at any edge, including mid-RUN:
  - state returns to IDLE and the current operation is discarded;
  - all internal registers clear;
  - all outputs go to 0.

## Timing
- Reset value of every output: `busy`, `done`, `d`, `bout`, `ovf` and `zero` are all 0.
- Start accepted at edge E0:
  - `busy` = 1 from E0 through E(W−1);
  - `done` = 1 for exactly the cycle between E(W) and E(W+1);
  - `d` and the flags are valid from E(W);
  - the next start can be accepted at E(W+2) at the earliest.
- Latency is W+1 cycles from the accepting edge to the end of the done pulse. Throughput is one operation per W+2 cycles.
- `rst` and `start` asserted at the same edge: `rst` wins and no operation starts.

## Configuration
- Macro `SERSUB_ADD_MODE_EN`.
- Defined:
  - Adds input port `op` (1 bit), latched with the operands: 0 = subtract, 1 = add.
  - In add mode the cell uses di = ai ^ bi ^ c and c_next = (ai & bi) | ((ai ^ bi) & c).
  - `bout` reports the final carry-out.
  - `ovf` = (a[W−1] == b[W−1]) && (d[W−1] != a[W−1]).
  - Latency and handshake are identical to subtract mode.
- Undefined:
  - No `op` port; the block always subtracts, exactly as described above.

## Test plan
All cases use W = 8.
- Basic subtract: reset, then start with a=0x05, b=0x03 → d=0x02, bout=0, ovf=0, zero=0. `done` is high exactly in the cycle after E8; `busy` is high for edges E0..E7.
- Unsigned borrow: a=0x03, b=0x05 → d=0xFE, bout=1, ovf=0, zero=0.
- Signed overflow: a=0x80, b=0x01 → d=0x7F, bout=0, ovf=1. Second case: a=0x7F, b=0xFF → d=0x80, bout=1, ovf=1.
- Zero result and hold:
  - a=0x5A, b=0x5A → d=0x00, zero=1, bout=0.
  - Outputs hold for 10 idle cycles.
  - A start during RUN does nothing, and no second done pulse appears.
- Reset mid-operation:
  - Assert `rst` at E4 of a 0x05−0x03 operation → next cycle busy=0, done=0, d=0, all flags 0.
  - A following start with a=0x10, b=0x01 → d=0x0F.
- With `SERSUB_ADD_MODE_EN`:
  - op=1, a=0xFF, b=0x01 → d=0x00, bout=1, zero=1, ovf=0.
  - op=1, a=0x7F, b=0x01 → d=0x80, ovf=1.
